esm_issue_reader: RTL and testbench
===================================

Name: esm_issue_reader

Overview:
- Consumer side of the ESM instruction-dependency table.
- The dependency analyser writes one entry per buffer slot: index, rd, rs1, rs2 (register 0 means "no operand / no write").
- This block tracks RAW/WAW hazards between the buffered entries and offers hazard-free slots to the execute stage over a valid/ready handshake.
- It frees a slot when that instruction's writeback is reported.

Parameters:
- bs, 16: number of instruction buffer slots (power of 2).
- regnum, 16: architectural registers; register address width is clog2(regnum).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- alloc_valid  in  1  write an entry this cycle
- alloc_index  in  clog2(bs)  target slot
- alloc_rd  in  clog2(regnum)  destination register, 0 = none
- alloc_rs1  in  clog2(regnum)  source 1, 0 = none
- alloc_rs2  in  clog2(regnum)  source 2, 0 = none/immediate
- alloc_ready  out  1  combinational: slot alloc_index is free
- issue_valid  out  1  registered: issue_index is ready to issue
- issue_index  out  clog2(bs)  registered: offered slot
- issue_ready  in  1  execute stage accepts
- wb_valid  in  1  instruction completed
- wb_index  in  clog2(bs)  completed slot
- occupancy  out  clog2(bs)+1  registered count of valid slots

Behaviour:
- Reset:
  - Clears all slot valid, issued and dep bits.
  - issue_valid=0, issue_index=0, occupancy=0, FSM=IDLE.
  - Reset mid-offer drops the offer with no acceptance.
- Per-slot state: valid, issued, rd, rs1, rs2, dep[bs-1:0] (slots this entry waits on).
- Allocation (edge with alloc_valid & alloc_ready):
  - Store the operands and set valid=1, issued=0.
  - dep[j]=1 iff slot j is valid, j != alloc_index, rd_j != 0, and rd_j equals alloc_rs1, alloc_rs2 or alloc_rd (RAW or WAW).
  - alloc_valid when the slot is not free: ignored, no state change.
- Writeback (edge with wb_valid, slot valid and issued):
  - Clear valid and issued.
  - Clear bit wb_index in every slot's dep.
  - wb to an invalid or unissued slot is ignored.
- Simultaneous alloc and wb on the same edge: the slot being written back counts as already complete, so the new entry gets no dep on it.
- Alloc and wb to the same slot on the same edge: wb takes effect first and the alloc is still rejected, because alloc_ready was sampled before the edge.
- Ready(i) = valid & ~issued & (dep==0).
- occupancy: +1 on an accepted alloc, -1 on an accepted wb, net 0 when both happen together; never exceeds bs.
- FSM:
  - IDLE: on an edge where any slot is ready, load issue_index with the selected slot, set issue_valid=1, go to OFFER.
  - OFFER: issue_index is held stable regardless of new allocations.
    - On an edge with issue_ready=1: mark the slot issued.
      - If another slot is ready, excluding the one just accepted, load it and stay in OFFER (back-to-back issue, 1 per cycle).
      - Otherwise clear issue_valid and go to IDLE.
- Default selection: lowest-index ready slot.
- Latency: an entry allocated with no deps at edge E0 is offered from edge E1. A dependent entry is offered at the edge after the writeback that clears its last dep.
- All-full: alloc_ready=0 for every index and occupancy=bs.
- Empty with an offer pending cannot occur; assert it in verification.

Optional Feature:
- Macro: ESM_OLDEST_FIRST_EN.
- Defined:
  - Adds a bs x bs age matrix; age[i][j]=1 means i was allocated before j.
  - Set on alloc relative to all valid slots; cleared for a slot on its writeback.
  - Selection picks the ready slot that no other ready slot is older than.
- Undefined: lowest-index selection, and no age storage is synthesised.

Test Plan:
- Reset, then alloc slot 3 (rd=5, rs1=1, rs2=2) -> issue_valid=1 with issue_index=3 at the next edge. With issue_ready=1, issue_valid drops after one cycle and occupancy=1.
- Alloc slot 0 (rd=4), then slot 1 (rs1=4) -> only slot 0 is offered. Accept and wb slot 0 -> slot 1 is offered at the next edge and occupancy steps 2->1.
- Alloc slot 2 with rd=0 and slot 5 with rs1=0, rs2=0 -> neither creates a dependency, so both issue on back-to-back cycles with issue_ready held 1.
- Hold issue_ready=0 while offering slot 6, then alloc a ready slot 1 -> issue_index stays 6 until accepted, and slot 1 is offered next.
- Fill all 16 slots -> occupancy=16 and alloc_ready=0. wb slot 7 and alloc slot 7 with rs1 equal to slot 7's rd on the same edge -> the alloc is rejected (alloc_ready was 0 before the edge); re-allocating slot 7 on the next edge creates no self-dependency.
- With ESM_OLDEST_FIRST_EN defined, allocate slot 9 then slot 2, both with no deps, and keep issue_ready=0 until both are ready -> slot 9 is offered first. Without the macro -> slot 2 is offered first.

Source files
------------

// File: rtl/esm_issue_reader.sv
// ESM dependency-table consumer: tracks RAW/WAW hazards between buffered slots and offers
// hazard-free slots to execute over valid/ready. Define ESM_OLDEST_FIRST_EN for age-ordered selection.
module esm_issue_reader #(
  parameter int bs = 16,
  parameter int regnum = 16,
  localparam int AW = $clog2(bs),
  localparam int RW = $clog2(regnum)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid,
  input  logic [AW-1:0] alloc_index,
  input  logic [RW-1:0] alloc_rd,
  input  logic [RW-1:0] alloc_rs1,
  input  logic [RW-1:0] alloc_rs2,
  output logic          alloc_ready,
  output logic          issue_valid,
  output logic [AW-1:0] issue_index,
  input  logic          issue_ready,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_index,
  output logic [AW:0]   occupancy
);

  typedef enum logic [0:0] {IDLE, OFFER} state_e;

  state_e        state_q, state_d;
  logic [bs-1:0] valid_q, valid_d;
  logic [bs-1:0] issued_q, issued_d;
  // Sources only matter when the entry is allocated, so only rd is retained per slot.
  logic [RW-1:0] rd_q [bs];
  logic [RW-1:0] rd_d [bs];
  logic [bs-1:0] dep_q [bs];
  logic [bs-1:0] dep_d [bs];
`ifdef ESM_OLDEST_FIRST_EN
  logic [bs-1:0] age_q [bs];
  logic [bs-1:0] age_d [bs];
  logic [bs-1:0] older;
`endif
  logic          issue_valid_q, issue_valid_d;
  logic [AW-1:0] issue_index_q, issue_index_d;
  logic [AW:0]   occ_q, occ_d;

  logic [bs-1:0] ready, mask, cand;
  logic [AW-1:0] sel;
  logic          found;
  logic          alloc_acc, wb_acc, accept;

  assign alloc_ready = ~valid_q[alloc_index];
  assign alloc_acc   = alloc_valid & alloc_ready;
  assign wb_acc      = wb_valid & valid_q[wb_index] & issued_q[wb_index];
  assign accept      = (state_q == OFFER) & issue_ready;

  assign issue_valid = issue_valid_q;
  assign issue_index = issue_index_q;
  assign occupancy   = occ_q;

  // Candidate selection; the slot currently on offer is excluded so a just-accepted
  // slot is never re-offered on the same edge.
  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < bs; i++) begin
      ready[i] = valid_q[i] & ~issued_q[i] & ~(|dep_q[i]);
    end
    mask = ready;
    if (state_q == OFFER) mask[issue_index_q] = 1'b0;
`ifdef ESM_OLDEST_FIRST_EN
    cand  = '0;
    older = '0;
    for (int unsigned i = 0; i < bs; i++) begin
      for (int unsigned j = 0; j < bs; j++) begin
        older[j] = age_q[j][i];
      end
      cand[i] = mask[i] & ~(|(mask & older));
    end
`else
    cand = mask;
`endif
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < bs; i++) begin
      if (cand[i] && !found) begin
        sel   = AW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d       = valid_q;
    issued_d      = issued_q;
    rd_d          = rd_q;
    dep_d         = dep_q;
    state_d       = state_q;
    issue_valid_d = issue_valid_q;
    issue_index_d = issue_index_q;
    occ_d         = occ_q;

    if (accept) issued_d[issue_index_q] = 1'b1;

    if (wb_acc) begin
      valid_d[wb_index]  = 1'b0;
      issued_d[wb_index] = 1'b0;
      for (int unsigned i = 0; i < bs; i++) begin
        dep_d[i][wb_index] = 1'b0;
      end
    end

    // A slot completing on this edge is treated as already done for the new entry.
    if (alloc_acc) begin
      valid_d[alloc_index]  = 1'b1;
      issued_d[alloc_index] = 1'b0;
      rd_d[alloc_index]     = alloc_rd;
      for (int unsigned j = 0; j < bs; j++) begin
        dep_d[alloc_index][j] = valid_q[j]
                                && (AW'(j) != alloc_index)
                                && !(wb_acc && (AW'(j) == wb_index))
                                && (rd_q[j] != '0)
                                && ((rd_q[j] == alloc_rs1) || (rd_q[j] == alloc_rs2)
                                    || (rd_q[j] == alloc_rd));
      end
    end

    case ({alloc_acc, wb_acc})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase

    case (state_q)
      IDLE: begin
        if (found) begin
          issue_index_d = sel;
          issue_valid_d = 1'b1;
          state_d       = OFFER;
        end
      end
      OFFER: begin
        if (issue_ready) begin
          if (found) begin
            issue_index_d = sel;
          end else begin
            issue_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: begin
        issue_valid_d = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

`ifdef ESM_OLDEST_FIRST_EN
  always_comb begin
    age_d = age_q;
    if (alloc_acc) begin
      for (int unsigned j = 0; j < bs; j++) begin
        age_d[alloc_index][j] = 1'b0;
        age_d[j][alloc_index] = valid_q[j] && (AW'(j) != alloc_index);
      end
    end
    if (wb_acc) begin
      for (int unsigned j = 0; j < bs; j++) begin
        age_d[wb_index][j] = 1'b0;
        age_d[j][wb_index] = 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      issued_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_index_q <= '0;
      occ_q         <= '0;
      for (int unsigned i = 0; i < bs; i++) begin
        rd_q[i]  <= '0;
        dep_q[i] <= '0;
`ifdef ESM_OLDEST_FIRST_EN
        age_q[i] <= '0;
`endif
      end
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      issued_q      <= issued_d;
      issue_valid_q <= issue_valid_d;
      issue_index_q <= issue_index_d;
      occ_q         <= occ_d;
      rd_q          <= rd_d;
      dep_q         <= dep_d;
`ifdef ESM_OLDEST_FIRST_EN
      age_q         <= age_d;
`endif
    end
  end

endmodule

// File: tb/tb_esm_issue_reader.sv
// Directed, table-driven bench for esm_issue_reader; selection-order expectations follow
// ESM_OLDEST_FIRST_EN when it is defined.
module tb_esm_issue_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic [3:0] alloc_index, alloc_rd, alloc_rs1, alloc_rs2;
  logic       alloc_ready;
  logic       issue_valid;
  logic [3:0] issue_index;
  logic       issue_ready;
  logic       wb_valid;
  logic [3:0] wb_index;
  logic [4:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ESM_OLDEST_FIRST_EN
  localparam int FIRST = 9, SECOND = 2;
`else
  localparam int FIRST = 2, SECOND = 9;
`endif

  esm_issue_reader #(.bs(16), .regnum(16)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_index(alloc_index), .alloc_rd(alloc_rd),
    .alloc_rs1(alloc_rs1), .alloc_rs2(alloc_rs2), .alloc_ready(alloc_ready),
    .issue_valid(issue_valid), .issue_index(issue_index), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_index(wb_index), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int av, ai, rd, rs1, rs2, ir, wv, wi;
    int e_ar, e_iv, e_ii, e_occ;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int av, ai, rd, rs1, rs2, ir, wv, wi, e_ar, e_iv, e_ii, e_occ);
    vec_t v;
    v.av = av; v.ai = ai; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.ir = ir; v.wv = wv; v.wi = wi;
    v.e_ar = e_ar; v.e_iv = e_iv; v.e_ii = e_ii; v.e_occ = e_occ;
    vecs.push_back(v);
  endtask

  task automatic drive(input int av, ai, rd, rs1, rs2, ir, wv, wi);
    alloc_valid = av[0];
    alloc_index = ai[3:0];
    alloc_rd    = rd[3:0];
    alloc_rs1   = rs1[3:0];
    alloc_rs2   = rs2[3:0];
    issue_ready = ir[0];
    wb_valid    = wv[0];
    wb_index    = wi[3:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // An offer with nothing buffered is illegal.
  always @(negedge clk) begin
    if (!rst && issue_valid) check("offer_nonempty", (occupancy != 0), 1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset issue_valid", issue_valid, 0);
    check("reset issue_index", issue_index, 0);
    check("reset occupancy", occupancy, 0);
    rst = 1'b0;

    //  av ai rd s1 s2 ir wv wi  ar iv ii occ
    // single entry, issue and writeback
    add(1, 3, 5, 1, 2, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 3, 1);
    add(0, 3, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
    add(0, 3, 0, 0, 0, 0, 1, 3,  0, 0, 0, 0);
    add(0, 3, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    // RAW: slot1 waits on slot0
    add(1, 0, 4, 0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(1, 1, 0, 4, 0, 0, 0, 0,  1, 1, 0, 2);
    add(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0);
    // zero registers create no deps; back-to-back issue
    add(1, 2, 0, 3, 0, 0, 0, 0,  1, 0, 0, 1);
    add(1, 5, 6, 0, 0, 1, 0, 0,  1, 1, 2, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 5, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1, 2,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 5,  1, 0, 0, 0);
    // held offer; wb to unissued slot and alloc to occupied slot are ignored
    add(1, 6, 3, 0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 6,  1, 1, 6, 1);
    add(1, 1, 0, 9, 0, 0, 0, 0,  1, 1, 6, 2);
    add(1, 6, 2, 6, 0, 0, 0, 0,  0, 1, 6, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 1, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1, 6,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0);
    // slots 9 then 2 both released by one writeback
    add(1, 0, 7, 0, 0, 1, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
    add(1, 9, 0, 7, 0, 0, 0, 0,  1, 0, 0, 2);
    add(1, 2, 0, 7, 0, 0, 0, 0,  1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, FIRST, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0,  1, 1, SECOND, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1, 9,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 2,  1, 0, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      v = vecs[k];
      drive(v.av, v.ai, v.rd, v.rs1, v.rs2, v.ir, v.wv, v.wi);
      #1;
      check($sformatf("v%0d alloc_ready", k), alloc_ready, v.e_ar);
      step();
      check($sformatf("v%0d issue_valid", k), issue_valid, v.e_iv);
      if (v.e_iv != 0) check($sformatf("v%0d issue_index", k), issue_index, v.e_ii);
      check($sformatf("v%0d occupancy", k), occupancy, v.e_occ);
    end

    // Fill every slot while issuing continuously.
    for (int i = 0; i < 16; i++) begin
      drive(1, i, i, 0, 0, 1, 0, 0);
      #1;
      check($sformatf("fill%0d alloc_ready", i), alloc_ready, 1);
      step();
    end
    check("full occupancy", occupancy, 16);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (4) step();
    check("full drained offers", issue_valid, 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, i, 0, 0, 0, 0, 0, 0);
      #1;
      check($sformatf("full alloc_ready[%0d]", i), alloc_ready, 0);
    end

    // wb and alloc to slot 7 on one edge: alloc rejected.
    drive(1, 7, 0, 7, 0, 0, 1, 7);
    #1;
    check("same-edge alloc_ready", alloc_ready, 0);
    step();
    check("same-edge occupancy", occupancy, 15);
    check("same-edge issue_valid", issue_valid, 0);
    drive(0, 7, 0, 0, 0, 0, 0, 0);
    #1;
    check("slot7 freed", alloc_ready, 1);
    drive(1, 7, 7, 7, 0, 0, 0, 0);
    step();
    check("realloc occupancy", occupancy, 16);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("realloc issue_valid", issue_valid, 1);
    check("realloc issue_index", issue_index, 7);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    step();
    check("realloc accepted", issue_valid, 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, i);
      step();
    end
    check("drain occupancy", occupancy, 0);

    // Reset while an offer is pending.
    drive(1, 4, 3, 0, 0, 0, 0, 0);
    step();
    drive(0, 4, 0, 0, 0, 0, 0, 0);
    step();
    check("pre-reset issue_valid", issue_valid, 1);
    check("pre-reset issue_index", issue_index, 4);
    #2 rst = 1'b1;
    #1;
    check("async reset issue_valid", issue_valid, 0);
    check("async reset issue_index", issue_index, 0);
    check("async reset occupancy", occupancy, 0);
    rst = 1'b0;
    #1;
    check("post-reset alloc_ready", alloc_ready, 1);
    step();
    check("post-reset no offer", issue_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
